// File: rtl/dm_wb_cache.sv
// dm_wb_cache: direct-mapped, write-back, write-allocate data cache.
// Hits complete in the request cycle. Misses become one-pulse line transactions on the
// 128-bit memory port. i_proc_finish flushes every dirty line and then parks in DONE.
// Optional build macro CACHE_PERF_EN adds the o_acc_cnt / o_miss_cnt counters.
module dm_wb_cache #(
    parameter int unsigned BIT_W     = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_LINES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_proc_cen,
    input  logic                 i_proc_wen,
    input  logic [ADDR_W-1:0]    i_proc_addr,
    input  logic [BIT_W-1:0]     i_proc_wdata,
    output logic [BIT_W-1:0]     o_proc_rdata,
    output logic                 o_proc_stall,
    input  logic                 i_proc_finish,
    output logic                 o_cache_finish,
    output logic                 o_mem_cen,
    output logic                 o_mem_wen,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [4*BIT_W-1:0]   o_mem_wdata,
    input  logic [4*BIT_W-1:0]   i_mem_rdata,
    input  logic                 i_mem_stall
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]          o_acc_cnt,
    output logic [31:0]          o_miss_cnt
`endif
);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = ADDR_W - 4 - IDX_W;
    localparam int unsigned LINE_W = 4 * BIT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    typedef enum logic [3:0] {
        StIdle, StWbReq, StWbWait, StRdReq, StRdWait, StFlScan, StFlReq, StFlWait, StDone
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;       // line under miss handling or flush scan
    logic [TAG_W-1:0]     r_req_tag;   // tag of the missing request
    logic                 r_fin_pend;  // finish seen while busy, served on return to IDLE
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_word;
    logic                 w_hit;
    logic                 w_idle_hit;
    logic                 w_miss;
    logic                 w_fill;
    logic [LINE_W-1:0]    w_line;
    logic [LINE_W-1:0]    w_line_st;
    logic [BIT_W-1:0]     w_rword;
    logic [ADDR_W-1:0]    w_victim_addr;
    logic [ADDR_W-1:0]    w_fill_addr;
    logic                 w_unused_addr;

    assign w_idx         = i_proc_addr[4 +: IDX_W];
    assign w_tag         = i_proc_addr[ADDR_W-1 -: TAG_W];
    assign w_word        = i_proc_addr[3:2];
    assign w_unused_addr = ^i_proc_addr[1:0];   // word-aligned accesses only
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle_hit    = (r_state == StIdle) && i_proc_cen && w_hit;
    assign w_miss        = (r_state == StIdle) && i_proc_cen && !w_hit;
    assign w_fill        = (r_state == StRdWait) && !i_mem_stall;
    assign w_line        = r_data[w_idx];
    assign w_victim_addr = {r_tag[r_idx], r_idx, 4'b0};
    assign w_fill_addr   = {r_req_tag, r_idx, 4'b0};

    assign o_proc_stall   = i_proc_cen && !((r_state == StIdle) && w_hit);
    assign o_proc_rdata   = (w_idle_hit && !i_proc_wen) ? w_rword : '0;
    assign o_cache_finish = (r_state == StDone);

    // Word select for loads and word merge for store hits.
    always_comb begin
        w_rword   = w_line[0 +: BIT_W];
        w_line_st = w_line;
        case (w_word)
            2'd0: begin w_rword = w_line[0*BIT_W +: BIT_W]; w_line_st[0*BIT_W +: BIT_W] = i_proc_wdata; end
            2'd1: begin w_rword = w_line[1*BIT_W +: BIT_W]; w_line_st[1*BIT_W +: BIT_W] = i_proc_wdata; end
            2'd2: begin w_rword = w_line[2*BIT_W +: BIT_W]; w_line_st[2*BIT_W +: BIT_W] = i_proc_wdata; end
            default: begin w_rword = w_line[3*BIT_W +: BIT_W]; w_line_st[3*BIT_W +: BIT_W] = i_proc_wdata; end
        endcase
    end

    // Memory port decode: request pulses in *Req, wen/addr/data held through *Wait.
    always_comb begin
        o_mem_cen   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        unique case (r_state)
            StWbReq, StFlReq: begin
                o_mem_cen   = 1'b1;
                o_mem_wen   = 1'b1;
                o_mem_addr  = w_victim_addr;
                o_mem_wdata = r_data[r_idx];
            end
            StWbWait, StFlWait: begin
                o_mem_wen   = 1'b1;
                o_mem_addr  = w_victim_addr;
                o_mem_wdata = r_data[r_idx];
            end
            StRdReq: begin
                o_mem_cen  = 1'b1;
                o_mem_addr = w_fill_addr;
            end
            StRdWait: o_mem_addr = w_fill_addr;
            default: ;
        endcase
    end

    // Line storage; tag/data are unreset, valid gates their use.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_data[r_idx] <= i_mem_rdata;
            r_tag[r_idx]  <= r_req_tag;
        end else if (w_idle_hit && i_proc_wen) begin
            r_data[w_idx] <= w_line_st;
        end
    end

    // Control FSM with valid/dirty bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_req_tag  <= '0;
            r_fin_pend <= 1'b0;
            r_valid    <= '0;
            r_dirty    <= '0;
        end else begin
            if (i_proc_finish) r_fin_pend <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (i_proc_cen) begin
                        if (w_hit) begin
                            if (i_proc_wen) r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_idx     <= w_idx;
                            r_req_tag <= w_tag;
                            r_state   <= r_dirty[w_idx] ? StWbReq : StRdReq;
                        end
                    end else if (i_proc_finish || r_fin_pend) begin
                        r_idx      <= '0;
                        r_fin_pend <= 1'b0;
                        r_state    <= StFlScan;
                    end
                end
                StWbReq: r_state <= StWbWait;
                StWbWait: begin
                    if (!i_mem_stall) begin
                        r_dirty[r_idx] <= 1'b0;
                        r_state        <= StRdReq;
                    end
                end
                StRdReq: r_state <= StRdWait;
                StRdWait: begin
                    if (!i_mem_stall) begin
                        r_valid[r_idx] <= 1'b1;
                        r_dirty[r_idx] <= 1'b0;
                        r_state        <= StIdle;
                    end
                end
                StFlScan: begin
                    if (r_dirty[r_idx]) r_state <= StFlReq;
                    else if (r_idx == LAST_IDX) r_state <= StDone;
                    else r_idx <= r_idx + IDX_W'(1);
                end
                StFlReq: r_state <= StFlWait;
                StFlWait: begin
                    if (!i_mem_stall) begin
                        r_dirty[r_idx] <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= StDone;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= StFlScan;
                        end
                    end
                end
                StDone: r_state <= StDone;
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef CACHE_PERF_EN
    logic [31:0] r_acc_cnt;
    logic [31:0] r_miss_cnt;

    // Completed-access and miss counters, wrapping at 2^32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (i_proc_cen && !o_proc_stall) r_acc_cnt <= r_acc_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_acc_cnt  = r_acc_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule
